// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults, word type and collector FSM states for the CNN datapath.
package cnn_pkg;
  localparam int DEF_IP_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_WIDTH = 3;
  typedef logic signed [2*DEF_IP_DATA_WIDTH-1:0] word_t;
  typedef enum logic {COLLECT, HOLD} state_t;
endpackage

// File: rtl/relu_unit.sv
// relu_unit: combinational ReLU; passes values through unchanged when disabled.
module relu_unit #(
  parameter int W  = 16,
  parameter int EN = 1
) (
  input  logic signed [W-1:0] i_x,
  output logic signed [W-1:0] o_y
);
  assign o_y = (EN != 0 && i_x[W-1]) ? '0 : i_x;
endmodule

// File: rtl/feature_map_collector.sv
// feature_map_collector: gathers N = ARRAY_WIDTH^2 convolution results (optionally ReLU'd)
// into a full feature map and holds it until the pooling stage accepts it.
module feature_map_collector
  import cnn_pkg::*;
#(
  parameter int IP_DATA_WIDTH = DEF_IP_DATA_WIDTH,
  parameter int ARRAY_WIDTH   = DEF_ARRAY_WIDTH,
  parameter int RELU_EN       = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [2*IP_DATA_WIDTH-1:0] in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [2*IP_DATA_WIDTH-1:0] out_vec [ARRAY_WIDTH*ARRAY_WIDTH-1:0],
  output logic                            frame_err
);
  localparam int DW = 2*IP_DATA_WIDTH;
  localparam int N  = ARRAY_WIDTH*ARRAY_WIDTH;
  localparam int IW = N > 1 ? $clog2(N) : 1;

  state_t                r_state, w_next;
  logic [IW-1:0]         r_idx;
  logic signed [DW-1:0]  r_vec [N-1:0];
  logic signed [DW-1:0]  w_relu;
  logic                  w_xfer, w_end, r_err;

  relu_unit #(.W(DW), .EN(RELU_EN)) u_relu (.i_x(in_data), .o_y(w_relu));

  assign w_xfer    = in_valid && in_ready;
  assign w_end     = r_idx == IW'(N-1);
  assign out_vec   = r_vec;
  assign frame_err = r_err;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_next;

  always_comb
    w_next = (r_state == COLLECT) ? ((w_xfer && w_end) ? HOLD : COLLECT)
                                  : (out_ready ? COLLECT : HOLD);

  always_comb begin
    in_ready  = r_state == COLLECT;
    out_valid = r_state == HOLD;
  end

  // in_last disagreeing with the element position is a framing error either way
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < N; k++) r_vec[k] <= '0;
    end else begin
      r_err <= w_xfer && (in_last != w_end);
      if (w_xfer) r_idx <= (w_end || in_last) ? '0 : r_idx + 1'b1;
      for (int k = 0; k < N; k++)
        if (w_xfer && r_idx == IW'(k)) r_vec[k] <= w_relu;
    end
endmodule

// File: tb/tb_feature_map_collector.sv
// tb_feature_map_collector: directed checks of framing, ReLU, backpressure and reset.
module tb_feature_map_collector;
  typedef logic signed [15:0] w_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
  w_t   in_data;
  w_t   out_vec [8:0];
  int   checks = 0, errors = 0, cyc = 0, t1, t2;
  w_t   ev [9];
  w_t   zv [9];

  feature_map_collector #(.IP_DATA_WIDTH(8), .ARRAY_WIDTH(3), .RELU_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input w_t exp [9]);
    for (int k = 0; k < 9; k++) chk($sformatf("%s[%0d]", tag, k), out_vec[k], exp[k]);
  endtask

  // called on a falling edge; returns on the falling edge after the word is accepted
  task automatic push(input w_t w, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = w; in_last = l;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $error("FAIL push_timeout observed=%0d expected=<20", n);
    end
    @(negedge clk);
  endtask

  task automatic push_frame(input w_t v [9], input logic lst);
    for (int i = 0; i < 9; i++) push(v[i], (i == 8) ? lst : 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    zv = '{default: 16'sd0};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    chk_vec("rst_vec", zv);
    rst_n = 1'b1;

    ev = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
    push_frame(ev, 1'b1);
    t1 = cyc;
    chk("f1_out_valid", out_valid, 1);
    chk("f1_in_ready", in_ready, 0);
    chk("f1_frame_err", frame_err, 0);
    chk_vec("f1_vec", ev);

    ev = '{-16'sd5, 16'sd3, -16'sd1, 16'sd0, 16'sd7, -16'sd128, 16'sd2, 16'sd4, 16'sh8000};
    push(ev[0], 1'b0);
    chk("f1_valid_one_cycle", out_valid, 0);
    for (int i = 1; i < 9; i++) push(ev[i], i == 8);
    t2 = cyc;
    chk("frame_period", t2 - t1, 10);
    chk("f2_out_valid", out_valid, 1);
    ev = '{16'sd0, 16'sd3, 16'sd0, 16'sd0, 16'sd7, 16'sd0, 16'sd2, 16'sd4, 16'sd0};
    chk_vec("f2_relu_vec", ev);

    push(16'sd1, 1'b0); push(16'sd2, 1'b0); push(16'sd3, 1'b0); push(16'sd4, 1'b1);
    chk("early_frame_err", frame_err, 1);
    chk("early_out_valid", out_valid, 0);
    chk("early_in_ready", in_ready, 1);
    push(16'sd10, 1'b0);
    chk("early_err_pulse", frame_err, 0);
    for (int i = 1; i < 9; i++) push(w_t'(10 + i), i == 8);
    ev = '{16'sd10, 16'sd11, 16'sd12, 16'sd13, 16'sd14, 16'sd15, 16'sd16, 16'sd17, 16'sd18};
    chk("f3_out_valid", out_valid, 1);
    chk("f3_frame_err", frame_err, 0);
    chk_vec("f3_vec", ev);

    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    ev = '{16'sd21, 16'sd22, 16'sd23, 16'sd24, 16'sd25, 16'sd26, 16'sd27, 16'sd28, 16'sd29};
    push_frame(ev, 1'b1);
    in_data = 16'sd99;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_frame_err", frame_err, 0);
      chk_vec("bp_vec", ev);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_err", frame_err, 0);

    for (int i = 1; i <= 5; i++) push(w_t'(i), 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk_vec("arst_vec", zv);
    @(negedge clk);
    rst_n = 1'b1;
    ev = '{16'sd31, 16'sd32, 16'sd33, 16'sd34, 16'sd35, 16'sd36, 16'sd37, 16'sd38, 16'sd39};
    push_frame(ev, 1'b1);
    chk("post_rst_valid", out_valid, 1);
    chk_vec("post_rst_vec", ev);

    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("hold_rst_valid", out_valid, 0);
    chk("hold_rst_vec0", out_vec[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    ev = '{16'sd41, 16'sd42, 16'sd43, 16'sd44, 16'sd45, 16'sd46, 16'sd47, 16'sd48, 16'sd49};
    push_frame(ev, 1'b0);
    chk("miss_frame_err", frame_err, 1);
    chk("miss_out_valid", out_valid, 1);
    chk_vec("miss_vec", ev);
    in_valid = 1'b0;
    @(negedge clk);
    chk("miss_err_pulse", frame_err, 0);
    chk("miss_release", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/feature_map_collector.md
FEATURE_MAP_COLLECTOR -- requirements
Module: feature_map_collector

Interface
REQ-001 SHALL have parameter IP_DATA_WIDTH, default 8: operand width; stored words are 2*IP_DATA_WIDTH bits signed.
REQ-002 SHALL have parameter ARRAY_WIDTH, default 3: feature map is ARRAY_WIDTH x ARRAY_WIDTH.
REQ-003 SHALL have parameter RELU_EN, default 1: 1 applies ReLU on capture; 0 stores raw values.
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 Port clk, input, 1: sole clock, rising edge.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1: in_data is valid.
REQ-008 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-009 Port in_data, input, signed 2*IP_DATA_WIDTH: one convolution result, row-major order.
REQ-010 Port in_last, input, 1: marks the final element of a frame.
REQ-011 Port out_valid, output, 1: out_vec holds a complete frame.
REQ-012 Port out_ready, input, 1: pooling stage takes out_vec.
REQ-013 Port out_vec, output, unpacked array [ARRAY_WIDTH*ARRAY_WIDTH-1:0] of signed 2*IP_DATA_WIDTH: full feature map; element k is the k-th accepted word.
REQ-014 Port frame_err, output, 1: one-cycle pulse on a framing error.

Function
REQ-015 SHALL implement an FSM with two states: COLLECT and HOLD.
REQ-016 An input transfer occurs only on a rising edge with in_valid=1 and in_ready=1.
REQ-017 in_ready SHALL be 1 in COLLECT and 0 in HOLD; it SHALL be combinational from state only.
REQ-018 On a transfer, the word SHALL be written to out_vec[idx]; idx (0 .. N-1, N = ARRAY_WIDTH*ARRAY_WIDTH) then SHALL increment.
REQ-019 With RELU_EN=1, a negative in_data SHALL be stored as 0; non-negative values SHALL be stored unchanged, with no truncation.
REQ-020 A transfer at idx=N-1 SHALL move the FSM to HOLD, set idx to 0, and assert out_valid on the next cycle (1-cycle latency from the last transfer).
REQ-021 In HOLD, out_vec and out_valid SHALL stay stable until out_valid=1 and out_ready=1; on that cycle the FSM SHALL return to COLLECT.
REQ-022 out_valid SHALL be 1 only in HOLD. The minimum frame period SHALL be N+1 cycles.
REQ-023 in_last=1 on a transfer with idx<N-1 (early end) SHALL discard the partial frame, reset idx to 0, stay in COLLECT, and pulse frame_err on the next cycle.
REQ-024 in_last=0 on the transfer at idx=N-1 (missing end) SHALL still complete the frame per REQ-020 and pulse frame_err on the next cycle.
REQ-025 in_valid or in_last while in HOLD SHALL be ignored, with no state change and no frame_err.
REQ-026 out_ready while in COLLECT SHALL be ignored.
REQ-027 out_vec entries not yet written in the current frame SHALL retain their previous values; downstream SHALL sample only when out_valid=1.

Reset
REQ-028 While rst_n=0: state=COLLECT, idx=0, out_valid=0, frame_err=0, all out_vec entries=0, in_ready=1 once state is COLLECT.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard all collected data immediately, without waiting for a clock edge.
REQ-030 The first transfer after rst_n deasserts SHALL be written to index 0.

Structure
REQ-031 A shared package cnn_pkg SHALL hold the default IP_DATA_WIDTH and ARRAY_WIDTH constants, the signed word typedef (2*IP_DATA_WIDTH bits), and the FSM state enum.
REQ-032 ReLU SHALL be a single combinational sub-module, relu_unit, parameterised by width and enable.
REQ-033 out_vec SHALL be sized and ordered so that it connects directly to the max-pooling stage's input_vec.

Verification (ARRAY_WIDTH=3, IP_DATA_WIDTH=8, RELU_EN=1)
REQ-034 Nine back-to-back words 1..9 with in_last on the 9th, out_ready=1 -> out_valid high for 1 cycle one cycle after the 9th transfer; out_vec[0..8]=1..9; frame period 10 cycles.
REQ-035 Words -5,3,-1,0,7,-128,2,4,-32768 -> out_vec = 0,3,0,0,7,0,2,4,0.
REQ-036 in_last on the 4th word, then a clean frame 10..18 -> frame_err pulses once after the 4th word; the next out_vec = 10..18.
REQ-037 A complete frame with out_ready=0 for 5 cycles while in_valid stays high -> in_ready=0 and out_vec stable throughout; the frame is released on the first out_ready=1.
REQ-038 rst_n pulsed low after 5 words -> out_valid=0 and out_vec all 0 immediately; the next 9 words form a correct frame.
REQ-039 9 words with in_last=0 throughout -> frame completes with correct out_vec; frame_err pulses once.
